// File: rtl/my_sys_mem_slave.sv
// Avalon-MM responder RAM with fixed waitrequest stalls and pipelined read latency.
// Optional pseudo-random extra stalls: define MY_SYS_MEM_SLAVE_STALL_EN.
module my_sys_mem_slave #(
    parameter int ADDR_W       = 8,
    parameter int WAIT_STATES  = 1,
    parameter int READ_LATENCY = 2,
    parameter int MAX_PENDING  = 4
) (
    input  logic        clk_clk,
    input  logic        clk_reset_reset,
    input  logic [31:0] slave_address,
    input  logic        slave_read,
    input  logic        slave_write,
    input  logic [31:0] slave_writedata,
    input  logic [3:0]  slave_byteenable,
    output logic [31:0] slave_readdata,
    output logic        slave_waitrequest,
    output logic        slave_readdatavalid
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_ACK  = 2'd2;
    localparam int DEPTH = 1 << ADDR_W;

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [3:0]  pending_q, pending_d;
    logic [READ_LATENCY-1:0] vld_q;
    logic [31:0] data_q [READ_LATENCY];
    logic [31:0] mem_q [DEPTH] = '{default: '0};

    logic              req, is_rd, in_range, rd_ok, go_ack, stall;
    logic              accept, rd_accept, wr_accept, rdv;
    logic [ADDR_W-1:0] word_idx;
    logic [31:0]       rd_word;
    logic              addr_lsb_unused;

    assign req       = slave_read | slave_write;
    assign is_rd     = slave_read & ~slave_write;
    assign in_range  = (slave_address[31:ADDR_W+2] == '0);
    assign word_idx  = slave_address[ADDR_W+1:2];
    assign addr_lsb_unused = ^slave_address[1:0];
    assign rd_ok     = ~is_rd | (pending_q < 4'(MAX_PENDING));
    assign go_ack    = rd_ok & ~stall;
    assign accept    = (state_q == S_ACK) & req;
    assign rd_accept = accept & is_rd;
    assign wr_accept = accept & slave_write & in_range;
    assign rdv       = vld_q[READ_LATENCY-1];
    assign rd_word   = in_range ? mem_q[word_idx] : 32'hDEADBEEF;

`ifdef MY_SYS_MEM_SLAVE_STALL_EN
    logic [15:0] lfsr_q;
    always_ff @(posedge clk_clk or posedge clk_reset_reset) begin
        if (clk_reset_reset) lfsr_q <= 16'hACE1;
        else lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end
    assign stall = lfsr_q[0];
`else
    assign stall = 1'b0;
`endif

    // WAIT lasts WAIT_STATES cycles, so the counter is loaded one short.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    if (WAIT_STATES > 0) begin
                        state_d = S_WAIT;
                        cnt_d   = 4'(WAIT_STATES - 1);
                    end else if (go_ack) begin
                        state_d = S_ACK;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = '0;
                    end
                end
            end
            S_WAIT: begin
                if (!req)              state_d = S_IDLE;
                else if (cnt_q != '0)  cnt_d   = cnt_q - 4'd1;
                else if (go_ack)       state_d = S_ACK;
            end
            S_ACK:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        pending_d = pending_q;
        if (rd_accept && !rdv)      pending_d = pending_q + 4'd1;
        else if (!rd_accept && rdv) pending_d = pending_q - 4'd1;
    end

    always_ff @(posedge clk_clk or posedge clk_reset_reset) begin
        if (clk_reset_reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            pending_q <= '0;
            vld_q     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            vld_q     <= READ_LATENCY'({vld_q, rd_accept});
        end
    end

    // Read data pipeline; stage 0 captures the word at the accept edge.
    genvar gi;
    generate
        for (gi = 0; gi < READ_LATENCY; gi++) begin : g_pipe
            always_ff @(posedge clk_clk or posedge clk_reset_reset) begin
                if (clk_reset_reset) begin
                    data_q[gi] <= '0;
                end else if (gi == 0) begin
                    if (rd_accept) data_q[gi] <= rd_word;
                end else begin
                    data_q[gi] <= data_q[(gi == 0) ? 0 : gi - 1];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk_clk) begin
        if (wr_accept) begin
            for (int b = 0; b < 4; b++) begin
                if (slave_byteenable[b]) mem_q[word_idx][8*b +: 8] <= slave_writedata[8*b +: 8];
            end
        end
    end

    assign slave_waitrequest   = (state_q != S_ACK);
    assign slave_readdatavalid = rdv;
    assign slave_readdata      = data_q[READ_LATENCY-1];
endmodule

// File: tb/tb_my_sys_mem_slave.sv
// Directed bench for my_sys_mem_slave: timing, byte enables, read ordering, range and reset.
module tb_my_sys_mem_slave;
    localparam int ADDR_W = 8, WAIT_STATES = 1, READ_LATENCY = 4, MAX_PENDING = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] address = '0, writedata = '0;
    logic        read = 1'b0, write = 1'b0;
    logic [3:0]  byteenable = '0;
    logic [31:0] rdata;
    logic        wreq, rdv;

    int checks = 0, errors = 0, cyc = 0, w = 0, base = 0;
    int acc_q[$];
    int lat_q[$];
    logic [31:0] got_q[$];

    my_sys_mem_slave #(.ADDR_W(ADDR_W), .WAIT_STATES(WAIT_STATES),
                       .READ_LATENCY(READ_LATENCY), .MAX_PENDING(MAX_PENDING)) dut (
        .clk_clk(clk), .clk_reset_reset(rst), .slave_address(address),
        .slave_read(read), .slave_write(write), .slave_writedata(writedata),
        .slave_byteenable(byteenable), .slave_readdata(rdata),
        .slave_waitrequest(wreq), .slave_readdatavalid(rdv));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
        $display("check %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        if (rdv === 1'b1) begin
            got_q.push_back(rdata);
            if (acc_q.size() > 0) lat_q.push_back(cyc - acc_q.pop_front() + 1);
            else lat_q.push_back(-1);
        end
    endtask

    task automatic idle();
        read = 1'b0;
        write = 1'b0;
    endtask

    // Presents a command, waits for acceptance and returns the stall ticks observed.
    task automatic cmd(input logic rd, input logic wr, input logic [31:0] addr,
                       input logic [31:0] data, input logic [3:0] be, output int waits);
        read = rd; write = wr; address = addr; writedata = data; byteenable = be;
        waits = 0;
        do begin
            tick();
            waits++;
        end while (wreq !== 1'b0 && waits < 60);
        chk("cmd_accept_wreq", 32'(wreq), 32'd0);
        tick();
        if (rd && !wr) acc_q.push_back(cyc);
    endtask

    task automatic drain(input int n);
        int b = 0;
        while (got_q.size() < n && b < 60) begin
            tick();
            b++;
        end
        chk("drain_count", 32'(got_q.size()), 32'(n));
    endtask

    task automatic pop_rd(input string tag, input logic [31:0] exp);
        if (got_q.size() > 0) begin
            chk(tag, got_q.pop_front(), exp);
            chk("read_latency", 32'(lat_q.pop_front()), 32'(READ_LATENCY));
        end
    endtask

    initial begin
        repeat (3) begin
            tick();
            chk("reset_wreq", 32'(wreq), 32'd1);
        end
        rst = 1'b0;
        repeat (20) begin
            tick();
            chk("idle_wreq", 32'(wreq), 32'd1);
            chk("idle_rdv", 32'(rdv), 32'd0);
            chk("idle_rdata", rdata, 32'd0);
        end

        // full write, stall timing, readback
        cmd(1'b0, 1'b1, 32'h10, 32'h11223344, 4'hF, w);
        chk("write_stall_ticks", 32'(w), 32'd2);
        cmd(1'b1, 1'b0, 32'h10, '0, '0, w);
        idle();
        drain(1);
        pop_rd("read_full_word", 32'h11223344);

        // partial byte-enable write
        cmd(1'b0, 1'b1, 32'h10, 32'hAABBCCDD, 4'b0101, w);
        cmd(1'b1, 1'b0, 32'h13, '0, '0, w);
        idle();
        drain(1);
        pop_rd("read_byteenable_merge", 32'h11BB33DD);

        // back-to-back reads with a single outstanding slot
        for (int i = 0; i < 4; i++) cmd(1'b0, 1'b1, 32'(i * 4), 32'(i + 1), 4'hF, w);
        for (int i = 0; i < 4; i++) begin
            cmd(1'b1, 1'b0, 32'(i * 4), '0, '0, w);
            chk("b2b_prior_returned", 32'(got_q.size()), 32'(i));
            chk("b2b_inflight", 32'(acc_q.size()), 32'd1);
        end
        idle();
        drain(4);
        for (int i = 0; i < 4; i++) pop_rd("b2b_order", 32'(i + 1));

        // out-of-range read and dropped write
        cmd(1'b1, 1'b0, 32'h0001_0000, '0, '0, w);
        idle();
        drain(1);
        pop_rd("oor_read", 32'hDEADBEEF);
        cmd(1'b0, 1'b1, 32'h0001_0000, 32'hFFFFFFFF, 4'hF, w);
        cmd(1'b1, 1'b0, 32'h0, '0, '0, w);
        idle();
        drain(1);
        pop_rd("oor_write_dropped", 32'd1);

        // read and write together: only the write happens
        cmd(1'b1, 1'b1, 32'h20, 32'h55, 4'hF, w);
        idle();
        repeat (8) tick();
        chk("rw_no_rdv", 32'(got_q.size()), 32'd0);
        cmd(1'b1, 1'b0, 32'h20, '0, '0, w);
        idle();
        drain(1);
        pop_rd("rw_write_won", 32'h55);

        // reset while a read is in flight
        cmd(1'b1, 1'b0, 32'h10, '0, '0, w);
        idle();
        tick();
        rst = 1'b1;
        #1;
        chk("mid_reset_wreq", 32'(wreq), 32'd1);
        tick();
        chk("mid_reset_rdv", 32'(rdv), 32'd0);
        chk("mid_reset_rdata", rdata, 32'd0);
        rst = 1'b0;
        acc_q.delete();
        repeat (8) tick();
        chk("reset_discards_read", 32'(got_q.size()), 32'd0);
        cmd(1'b1, 1'b0, 32'h10, '0, '0, w);
        idle();
        drain(1);
        pop_rd("post_reset_read", 32'h11BB33DD);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
